// File: rtl/bf_pingpong_capture_pkg.sv
// Shared state codes, CSR map and status-word layout for the ping-pong capture buffer.
package bf_pingpong_capture_pkg;

  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_FILL  = 2'd1,
    ST_DROP  = 2'd2
  } wr_state_e;

  localparam int unsigned CSR_STATUS_OFS  = 0;
  localparam int unsigned CSR_RELEASE_OFS = 1;

  localparam int unsigned STAT_FULL_LSB   = 0;
  localparam int unsigned STAT_WBANK      = 2;
  localparam int unsigned STAT_OVF        = 3;
  localparam int unsigned STAT_SYNCERR    = 4;
  localparam int unsigned STAT_OVFCNT_LSB = 5;

  localparam int unsigned BANK0_MASK_DEF = 0;
  localparam int unsigned BANK1_MASK_DEF = 1;
  localparam int unsigned CSR_MASK_DEF   = 2;

endpackage

// File: rtl/bf_capture_dpram.sv
// Simple dual-port RAM holding both banks: write port in the ADC domain,
// registered read port in the Blackfin domain. Contents are never reset.
module bf_capture_dpram #(
  parameter int DATA_W = 16,
  parameter int AW     = 14
) (
  input  logic              wr_clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rd_clk_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**AW];

  always_ff @(posedge wr_clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge rd_clk_i) begin
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/bf_pingpong_capture.sv
// Ping-pong capture of interleaved ADC frames into two banks, each held for the DSP
// until released over the Blackfin async bus; status and release live in a CSR window.
module bf_pingpong_capture
  import bf_pingpong_capture_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 13,
  parameter int NUM_CH     = 4,
  parameter int BF_ADDR_W  = 16,
  parameter int BANK0_MASK = BANK0_MASK_DEF,
  parameter int BANK1_MASK = BANK1_MASK_DEF,
  parameter int CSR_MASK   = CSR_MASK_DEF,
  parameter int OVF_W      = 8
) (
  input  logic                 ADC_I_clk,
  input  logic                 I_rst,
  input  logic                 BF_I_clk,
  input  logic                 ADC_I_dataValid,
  input  logic [DATA_W-1:0]    ADC_I_data,
  input  logic                 ADC_I_frameStart,
  input  logic [BF_ADDR_W-1:0] BF_I_addr,
  input  logic                 BF_I_bankSelect,
  input  logic                 BF_I_are,
  input  logic                 BF_I_awe,
  inout  wire  [DATA_W-1:0]    BF_T_dataBus,
  output logic                 BF_O_ardy,
  output logic [1:0]           O_bankFull,
  output logic                 O_irq,
  output logic                 O_writeBank,
  output logic                 O_overflow
);

  localparam int SEL_W  = BF_ADDR_W - ADDR_W;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int STAT_W = STAT_OVFCNT_LSB + OVF_W;

  // ---------------- ADC domain ----------------
  wr_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CH_W-1:0]    chan_q, chan_d, chan_inc;
  logic               wbank_q, wbank_d;
  logic [1:0]         full_q, full_d, full_free, rel_clr;
  logic               irq_q;
  logic               ovf_q, ovf_d;
  logic [OVF_W-1:0]   ovfcnt_q, ovfcnt_d, ovfgray_q;
  logic               syncerr_q, syncerr_d;
  logic [1:0]         rel_s1_q, rel_s2_q, rel_s3_q;
  logic               ram_we;

  // BF-domain signals referenced by the ADC side
  logic [1:0]         rel_tog_q;

  assign chan_inc  = (NUM_CH == 1) ? '0 : chan_q + CH_W'(1);
  assign rel_clr   = (rel_s2_q ^ rel_s3_q) & full_q;
  assign full_free = full_q & ~rel_clr;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    chan_d    = chan_q;
    wbank_d   = wbank_q;
    full_d    = full_free;
    ovf_d     = ovf_q;
    ovfcnt_d  = ovfcnt_q;
    syncerr_d = syncerr_q;
    ram_we    = 1'b0;
    case (state_q)
      ST_ALIGN: begin
        if (ADC_I_dataValid && ADC_I_frameStart) begin
          ram_we  = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          chan_d  = chan_inc;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (ADC_I_dataValid) begin
          ram_we = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          chan_d = chan_inc;
          if (ADC_I_frameStart && (chan_q != '0)) syncerr_d = 1'b1;
          if (addr_q == '1) begin
            full_d[wbank_q] = 1'b1;
            // A release landing this very cycle already counts as free.
            if (!full_free[~wbank_q]) wbank_d = ~wbank_q;
            else                      state_d = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (ADC_I_dataValid) begin
          ovf_d = 1'b1;
          if (ovfcnt_q != '1) ovfcnt_d = ovfcnt_q + OVF_W'(1);
        end
        if (full_free != 2'b11) begin
          state_d = ST_ALIGN;
          wbank_d = full_free[0];
          addr_d  = '0;
          chan_d  = '0;
        end
      end
      default: state_d = ST_ALIGN;
    endcase
    if (|rel_clr) begin
      ovf_d    = 1'b0;
      ovfcnt_d = '0;
    end
  end

  always_ff @(posedge ADC_I_clk) begin
    if (I_rst) begin
      state_q   <= ST_ALIGN;
      addr_q    <= '0;
      chan_q    <= '0;
      wbank_q   <= 1'b0;
      full_q    <= 2'b00;
      irq_q     <= 1'b0;
      ovf_q     <= 1'b0;
      ovfcnt_q  <= '0;
      ovfgray_q <= '0;
      syncerr_q <= 1'b0;
      rel_s1_q  <= 2'b00;
      rel_s2_q  <= 2'b00;
      rel_s3_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      chan_q    <= chan_d;
      wbank_q   <= wbank_d;
      full_q    <= full_d;
      irq_q     <= |full_d;
      ovf_q     <= ovf_d;
      ovfcnt_q  <= ovfcnt_d;
      ovfgray_q <= ovfcnt_d ^ (ovfcnt_d >> 1);
      syncerr_q <= syncerr_d;
      rel_s1_q  <= rel_tog_q;
      rel_s2_q  <= rel_s1_q;
      rel_s3_q  <= rel_s2_q;
    end
  end

  assign O_bankFull  = full_q;
  assign O_irq       = irq_q;
  assign O_writeBank = wbank_q;
  assign O_overflow  = ovf_q;

  // ---------------- Blackfin domain ----------------
  logic              bf_rst_s1_q, bf_rst_q;
  logic [SEL_W-1:0]  region;
  logic [ADDR_W-1:0] offs;
  logic              is_b1, is_csr, sel, wr_rel, rd_status;
  logic              wr_q, sel_q, rd_csr_q;
  logic [DATA_W-1:0] csr_dat_q, ram_rdat, rd_dat;
  logic [1:0]        full_s1_q, full_s2_q;
  logic              wbank_s1_q, wbank_s2_q, ovf_s1_q, ovf_s2_q, serr_s1_q, serr_s2_q;
  logic [OVF_W-1:0]  gray_s1_q, gray_s2_q, ovf_bin;
  logic [STAT_W-1:0] stat_raw;

  always_ff @(posedge BF_I_clk) begin
    bf_rst_s1_q <= I_rst;
    bf_rst_q    <= bf_rst_s1_q;
  end

  assign region    = BF_I_addr[BF_ADDR_W-1:ADDR_W];
  assign offs      = BF_I_addr[ADDR_W-1:0];
  assign is_b1     = (region == SEL_W'(BANK1_MASK));
  assign is_csr    = (region == SEL_W'(CSR_MASK));
  assign sel       = BF_I_bankSelect & BF_I_are &
                     ((region == SEL_W'(BANK0_MASK)) | is_b1 | is_csr);
  assign wr_rel    = BF_I_bankSelect & BF_I_awe & is_csr & (offs == ADDR_W'(CSR_RELEASE_OFS));
  assign rd_status = is_csr & (offs == ADDR_W'(CSR_STATUS_OFS));

  always_comb begin
    for (int i = 0; i < OVF_W; i++) ovf_bin[i] = ^(gray_s2_q >> i);
  end

  always_comb begin
    stat_raw                                 = '0;
    stat_raw[STAT_FULL_LSB +: 2]             = full_s2_q;
    stat_raw[STAT_WBANK]                     = wbank_s2_q;
    stat_raw[STAT_OVF]                       = ovf_s2_q;
    stat_raw[STAT_SYNCERR]                   = serr_s2_q;
    stat_raw[STAT_OVFCNT_LSB +: OVF_W]       = ovf_bin;
  end

  always_ff @(posedge BF_I_clk) begin
    if (bf_rst_q) begin
      wr_q       <= 1'b0;
      rel_tog_q  <= 2'b00;
      sel_q      <= 1'b0;
      rd_csr_q   <= 1'b0;
      csr_dat_q  <= '0;
      full_s1_q  <= 2'b00;
      full_s2_q  <= 2'b00;
      wbank_s1_q <= 1'b0;
      wbank_s2_q <= 1'b0;
      ovf_s1_q   <= 1'b0;
      ovf_s2_q   <= 1'b0;
      serr_s1_q  <= 1'b0;
      serr_s2_q  <= 1'b0;
      gray_s1_q  <= '0;
      gray_s2_q  <= '0;
    end else begin
      // One toggle per write strobe, however long awe is held.
      wr_q <= wr_rel;
      if (wr_rel && !wr_q) rel_tog_q <= rel_tog_q ^ BF_T_dataBus[1:0];
      sel_q      <= sel;
      rd_csr_q   <= is_csr;
      csr_dat_q  <= rd_status ? DATA_W'(stat_raw) : '0;
      full_s1_q  <= full_q;
      full_s2_q  <= full_s1_q;
      wbank_s1_q <= wbank_q;
      wbank_s2_q <= wbank_s1_q;
      ovf_s1_q   <= ovf_q;
      ovf_s2_q   <= ovf_s1_q;
      serr_s1_q  <= syncerr_q;
      serr_s2_q  <= serr_s1_q;
      gray_s1_q  <= ovfgray_q;
      gray_s2_q  <= gray_s1_q;
    end
  end

  bf_capture_dpram #(
    .DATA_W (DATA_W),
    .AW     (ADDR_W + 1)
  ) u_ram (
    .wr_clk_i (ADC_I_clk),
    .we_i     (ram_we),
    .waddr_i  ({wbank_q, addr_q}),
    .wdata_i  (ADC_I_data),
    .rd_clk_i (BF_I_clk),
    .raddr_i  ({is_b1, offs}),
    .rdata_o  (ram_rdat)
  );

  assign rd_dat       = rd_csr_q ? csr_dat_q : ram_rdat;
  assign BF_O_ardy    = sel & sel_q;
  assign BF_T_dataBus = BF_O_ardy ? rd_dat : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bf_pingpong_capture.sv
// Directed bench: ADC fill/drop/release/reset scenarios with table-driven Blackfin read-back.
module tb_bf_pingpong_capture;

  localparam int DW = 16;

  logic          adc_clk = 1'b0;
  logic          bf_clk  = 1'b0;
  logic          rst     = 1'b1;
  logic          vld     = 1'b0;
  logic [DW-1:0] din     = '0;
  logic          fs      = 1'b0;
  logic [15:0]   bf_addr = '0;
  logic          bs = 1'b0, are = 1'b0, awe = 1'b0;
  logic          tb_oe = 1'b0;
  logic [DW-1:0] tb_dat = '0;
  wire  [DW-1:0] bf_bus;
  logic          ardy;
  logic [1:0]    bank_full;
  logic          irq, wbank, ovf;

  int checks   = 0;
  int failures = 0;

  assign bf_bus = tb_oe ? tb_dat : {DW{1'bz}};

  // ADC edges land on multiples of 10, Blackfin edges on 5+12k: never coincident.
  always #10 adc_clk = ~adc_clk;
  initial begin
    #5;
    forever #12 bf_clk = ~bf_clk;
  end

  bf_pingpong_capture #(
    .DATA_W(16), .ADDR_W(4), .NUM_CH(4), .BF_ADDR_W(16),
    .BANK0_MASK(0), .BANK1_MASK(1), .CSR_MASK(2), .OVF_W(8)
  ) dut (
    .ADC_I_clk        (adc_clk),
    .I_rst            (rst),
    .BF_I_clk         (bf_clk),
    .ADC_I_dataValid  (vld),
    .ADC_I_data       (din),
    .ADC_I_frameStart (fs),
    .BF_I_addr        (bf_addr),
    .BF_I_bankSelect  (bs),
    .BF_I_are         (are),
    .BF_I_awe         (awe),
    .BF_T_dataBus     (bf_bus),
    .BF_O_ardy        (ardy),
    .O_bankFull       (bank_full),
    .O_irq            (irq),
    .O_writeBank      (wbank),
    .O_overflow       (ovf)
  );

  typedef struct {
    int          phase;
    logic [15:0] addr;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t vecs[$];

  function automatic logic [15:0] ba(input int region, input int ofs);
    return 16'((region << 4) | ofs);
  endfunction

  task automatic add(input int p, input logic [15:0] a, input logic [15:0] e);
    rd_vec_t v;
    v.phase = p; v.addr = a; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic f);
    @(negedge adc_clk);
    vld = 1'b1; din = d; fs = f;
    @(posedge adc_clk);
  endtask

  task automatic adc_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge adc_clk);
      vld = 1'b0; fs = 1'b0;
    end
  endtask

  task automatic chk_adc(input string tag, input logic [1:0] e_full, input logic e_irq,
                         input logic e_wb, input logic e_ovf);
    chk({tag, "_bankFull"},  bank_full, e_full);
    chk({tag, "_irq"},       irq,       e_irq);
    chk({tag, "_writeBank"}, wbank,     e_wb);
    chk({tag, "_overflow"},  ovf,       e_ovf);
  endtask

  task automatic bf_wait(input int n);
    repeat (n) @(negedge bf_clk);
  endtask

  task automatic bf_read(input logic [15:0] a, output logic [15:0] d,
                         output logic ar1, output logic ar2);
    @(negedge bf_clk);
    awe = 1'b0; tb_oe = 1'b0; bf_addr = a; bs = 1'b1; are = 1'b1;
    #3;
    ar1 = ardy;
    @(negedge bf_clk);
    ar2 = ardy;
    d   = bf_bus;
    are = 1'b0; bs = 1'b0;
    @(negedge bf_clk);
  endtask

  // Returns right on the Blackfin edge that registers the release toggle.
  task automatic csr_write(input logic [15:0] v);
    @(negedge bf_clk);
    awe = 1'b0; are = 1'b0; bs = 1'b0; tb_oe = 1'b0;
    @(negedge bf_clk);
    bf_addr = ba(2, 1); bs = 1'b1; awe = 1'b1; tb_dat = v; tb_oe = 1'b1;
    @(posedge bf_clk);
  endtask

  task automatic run_phase(input int p);
    logic [15:0] d;
    logic        a1, a2;
    foreach (vecs[i]) begin
      if (vecs[i].phase == p) begin
        bf_read(vecs[i].addr, d, a1, a2);
        chk($sformatf("p%0d_ardy_cycle1_a%04h", p, vecs[i].addr), a1, 1'b0);
        chk($sformatf("p%0d_ardy_cycle2_a%04h", p, vecs[i].addr), a2, 1'b1);
        chk($sformatf("p%0d_data_a%04h", p, vecs[i].addr), d, vecs[i].exp);
      end
    end
  endtask

  initial begin
    repeat (20000) @(posedge adc_clk);
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // Read-back table: {phase, address, expected word}. Status word layout:
    // [12:5] ovfCnt, [4] syncErr, [3] overflow, [2] writeBank, [1:0] bankFull.
    for (int i = 0; i < 16; i++) add(1, ba(0, i), 16'(i));
    add(1, ba(2, 0), 16'h0005);
    add(2, ba(2, 0), 16'h010F);
    for (int i = 0; i < 16; i++) add(2, ba(1, i), 16'(16 + i));
    add(2, ba(0, 3), 16'h0003);
    add(3, ba(2, 0), 16'h0002);
    add(4, ba(2, 0), 16'h0012);
    for (int i = 0; i < 15; i++) add(4, ba(0, i), 16'(16'h0100 + i));
    add(5, ba(2, 0), 16'h0015);
    add(5, ba(0, 15), 16'h010F);
    add(5, ba(1, 0), 16'h0200);
    add(6, ba(2, 0), 16'h0000);
    add(6, ba(0, 0), 16'h0401);
    add(6, ba(0, 1), 16'h0402);
    add(6, ba(0, 2), 16'h0102);
    add(6, ba(1, 0), 16'h0200);
    add(6, ba(1, 6), 16'h0206);

    // Reset state
    adc_idle(6);
    chk_adc("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    adc_idle(2);

    // 1: one bank of aligned frames
    for (int i = 0; i < 16; i++) push(16'(i), (i % 4) == 0);
    adc_idle(1);
    chk_adc("fill0", 2'b01, 1'b1, 1'b1, 1'b0);
    bf_wait(4);
    run_phase(1);

    // 2: second bank fills, then eight samples are dropped
    for (int i = 16; i < 32; i++) push(16'(i), (i % 4) == 0);
    adc_idle(1);
    chk_adc("fill1", 2'b11, 1'b1, 1'b1, 1'b0);
    for (int i = 32; i < 40; i++) push(16'(i), (i % 4) == 0);
    adc_idle(1);
    chk_adc("drop", 2'b11, 1'b1, 1'b1, 1'b1);
    bf_wait(4);
    run_phase(2);

    // 3: release bank 0, writer re-aligns into bank 0
    void'(csr_write(16'h0001));
    adc_idle(6);
    chk_adc("rel0", 2'b10, 1'b1, 1'b0, 1'b0);
    bf_wait(4);
    run_phase(3);

    // 4: unaligned frameStart on channel 2 (sample 6); leave the last word unwritten
    push(16'hAAAA, 1'b0);
    push(16'hBBBB, 1'b0);
    for (int i = 0; i < 15; i++) push(16'(16'h0100 + i), (i == 0) || (i == 6) || (i == 8) || (i == 12));
    adc_idle(1);
    chk_adc("syncerr", 2'b10, 1'b1, 1'b0, 1'b0);
    bf_wait(4);
    run_phase(4);

    // 5: bank 1 released exactly as bank 0's last word is written
    void'(csr_write(16'h0002));
    @(posedge adc_clk);
    @(posedge adc_clk);
    push(16'h010F, 1'b0);
    push(16'h0200, 1'b1);
    adc_idle(1);
    chk_adc("relLast", 2'b01, 1'b1, 1'b1, 1'b0);
    bf_wait(4);
    run_phase(5);

    // 6: reset mid-fill at addr 7 of bank 1
    for (int i = 1; i < 7; i++) push(16'(16'h0200 + i), 1'b0);
    @(negedge adc_clk);
    vld = 1'b0; fs = 1'b0; rst = 1'b1;
    @(negedge adc_clk);
    chk_adc("midrst", 2'b00, 1'b0, 1'b0, 1'b0);
    adc_idle(2);
    rst = 1'b0;
    adc_idle(2);
    push(16'h0400, 1'b0);
    push(16'h0401, 1'b1);
    push(16'h0402, 1'b0);
    adc_idle(1);
    chk_adc("restart", 2'b00, 1'b0, 1'b0, 1'b0);
    bf_wait(6);
    run_phase(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
